// File: rtl/mlaccel_spi_slave.sv
// mlaccel_spi_slave: SPI mode-3 target front-end, oversampled in the system clock domain.
// Build option: define SPI_TRISTATE_EN to float spi_miso whenever no frame is active.
module mlaccel_spi_slave #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] TX_FILL     = 8'hFF
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       spi_csb,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_first,
  output logic       frame_active,
  output logic       frame_end,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] RESYNC = 2'd2;
  localparam logic [1:0] SETTLE = 2'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] csb_sync;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   csb_p1;
  logic                   clk_p1;
  logic                   csb_p0;
  logic                   clk_p0;
  logic                   mosi_p0;
  logic                   csb_fall;
  logic                   csb_rise;
  logic                   clk_fall;
  logic                   clk_rise;
  logic [1:0]             state;
  logic [1:0]             settle_cnt;
  logic                   settled;
  logic [2:0]             bit_cnt;
  logic                   first_pend;
  logic                   load_pend;
  logic                   load_now;
  logic [7:0]             rx_sh;
  logic [7:0]             tx_sh;
  logic                   miso_q;

  // Sync stage boundary: last synchroniser flop compared against its registered copy
  assign csb_p0   = csb_sync[SYNC_STAGES-1];
  assign clk_p0   = clk_sync[SYNC_STAGES-1];
  assign mosi_p0  = mosi_sync[SYNC_STAGES-1];
  assign csb_fall = csb_p1 & ~csb_p0;
  assign csb_rise = ~csb_p1 & csb_p0;
  assign clk_fall = clk_p1 & ~clk_p0;
  assign clk_rise = ~clk_p1 & clk_p0;
  assign settled  = (settle_cnt == SETTLE);

  assign frame_active = ~csb_p0;

  // A tx byte is taken at frame start and in the cycle after each completed byte
  assign load_now = resetn &
                    (((state == IDLE) & csb_fall) | ((state == ACTIVE) & load_pend));
  assign tx_ready = load_now & tx_valid;

`ifdef SPI_TRISTATE_EN
  assign spi_miso = (state == ACTIVE) ? miso_q : 1'bz;
`else
  assign spi_miso = (state == ACTIVE) ? miso_q : 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      csb_sync   <= '1;
      clk_sync   <= '1;
      mosi_sync  <= '1;
      csb_p1     <= 1'b1;
      clk_p1     <= 1'b1;
      // Chip select still low here means a frame was cut by reset: sit it out
      state      <= spi_csb ? IDLE : RESYNC;
      settle_cnt <= 2'd0;
      bit_cnt    <= 3'd0;
      first_pend <= 1'b0;
      load_pend  <= 1'b0;
      rx_data    <= 8'd0;
      rx_valid   <= 1'b0;
      rx_first   <= 1'b0;
      frame_end  <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      csb_sync   <= {csb_sync[SYNC_STAGES-2:0], spi_csb};
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
      mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      csb_p1     <= csb_p0;
      clk_p1     <= clk_p0;
      rx_valid   <= 1'b0;
      rx_first   <= 1'b0;
      frame_end  <= 1'b0;
      if (!settled) settle_cnt <= settle_cnt + 2'd1;

      case (state)
        IDLE: begin
          load_pend <= 1'b0;
          if (csb_fall) begin
            state      <= ACTIVE;
            bit_cnt    <= 3'd0;
            first_pend <= 1'b1;
          end
        end
        ACTIVE: begin
          load_pend <= 1'b0;
          if (clk_rise) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data    <= {rx_sh[6:0], mosi_p0};
              rx_valid   <= 1'b1;
              rx_first   <= first_pend;
              first_pend <= 1'b0;
              load_pend  <= 1'b1;
            end
          end else if (clk_fall) begin
            miso_q <= tx_sh[7];
          end
          // A byte completing in the same cycle is still delivered above
          if (csb_rise) begin
            state     <= IDLE;
            frame_end <= 1'b1;
            bit_cnt   <= 3'd0;
            load_pend <= 1'b0;
          end
        end
        RESYNC: begin
          bit_cnt   <= 3'd0;
          load_pend <= 1'b0;
          if (settled && csb_p0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shift stage boundary: data registers carry no reset
  always_ff @(posedge clock) begin
    if (state == ACTIVE && clk_rise) rx_sh <= {rx_sh[6:0], mosi_p0};
    if (load_now) begin
      tx_sh <= tx_valid ? tx_data : TX_FILL;
    end else if (state == ACTIVE && clk_fall) begin
      tx_sh <= {tx_sh[6:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_mlaccel_spi_slave.sv
// Directed bench for mlaccel_spi_slave: host-side SPI mode-3 driver plus strobe monitor.
module tb_mlaccel_spi_slave;

  logic       clock = 1'b0;
  logic       resetn;
  logic       spi_csb;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_miso;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_first;
  logic       frame_active;
  logic       frame_end;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] rxq_d[$];
  logic       rxq_f[$];
  int         fe_cnt = 0;
  int         tr_cnt = 0;
  int         cyc    = 0;
  int         rx_cyc = 0;
  int         fe_cyc = 0;

  mlaccel_spi_slave dut (
    .clock        (clock),
    .resetn       (resetn),
    .spi_csb      (spi_csb),
    .spi_clk      (spi_clk),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_first     (rx_first),
    .frame_active (frame_active),
    .frame_end    (frame_end),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (rx_valid) begin
      rxq_d.push_back(rx_data);
      rxq_f.push_back(rx_first);
      rx_cyc = cyc;
    end
    if (frame_end) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
    if (tx_ready) tr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rx_d_at(input int i);
    return (i < rxq_d.size()) ? rxq_d[i] : 8'hEE;
  endfunction

  function automatic logic rx_f_at(input int i);
    return (i < rxq_f.size()) ? rxq_f[i] : 1'bx;
  endfunction

  task automatic clr();
    rxq_d.delete();
    rxq_f.delete();
    fe_cnt = 0;
    tr_cnt = 0;
  endtask

  // Sends the top nbits of mo; txv>=0 sets tx_valid after the first bit
  task automatic spi_byte(input logic [7:0] mo, input int nbits, input int txv,
                          output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_clk  = 1'b0;
      spi_mosi = mo[i];
      #30 spi_clk = 1'b1;
      #30 mi[i] = spi_miso;
      if (i == 7 && txv >= 0) tx_valid = (txv != 0);
    end
  endtask

  logic [7:0] r0, r1, r2, b;
  logic       miso_rst;

  initial begin
    resetn   = 1'b0;
    spi_csb  = 1'b1;
    spi_clk  = 1'b1;
    spi_mosi = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
`ifdef SPI_TRISTATE_EN
    miso_rst = 1'bz;
`else
    miso_rst = 1'b0;
`endif

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_rx_first", {31'd0, rx_first}, 32'd0);
    check("rst_frame_end", {31'd0, frame_end}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
    check("rst_frame_active", {31'd0, frame_active}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_miso", {31'd0, spi_miso}, {31'd0, miso_rst});
    @(posedge clock);
    #2 resetn = 1'b1;
    repeat (6) @(posedge clock);
    #2;

    // Single frame 0x21, 0x05
    clr();
    spi_csb = 1'b0;
    #30;
    check("frame_active_hi", {31'd0, frame_active}, 32'd1);
    spi_byte(8'h21, 8, -1, r0);
    spi_byte(8'h05, 8, -1, r1);
    spi_csb = 1'b1;
    #100;
    check("sf_rx_count", rxq_d.size(), 32'd2);
    check("sf_d0", {24'd0, rx_d_at(0)}, 32'h21);
    check("sf_f0", {31'd0, rx_f_at(0)}, 32'd1);
    check("sf_d1", {24'd0, rx_d_at(1)}, 32'h05);
    check("sf_f1", {31'd0, rx_f_at(1)}, 32'd0);
    check("sf_frame_end", fe_cnt, 32'd1);
    check("sf_miso_fill", {24'd0, r0}, 32'hFF);
    check("sf_tx_ready", tr_cnt, 32'd0);

    // Response after command 0x22, then underrun
    clr();
    tx_data = 8'hA5;
    spi_csb = 1'b0;
    #30;
    spi_byte(8'h22, 8, 1, r0);
    spi_byte(8'h00, 8, 0, r1);
    spi_byte(8'h00, 8, -1, r2);
    spi_csb = 1'b1;
    #100;
    check("rsp_rx_count", rxq_d.size(), 32'd3);
    check("rsp_cmd", {24'd0, rx_d_at(0)}, 32'h22);
    check("rsp_cmd_first", {31'd0, rx_f_at(0)}, 32'd1);
    check("rsp_miso_b0", {24'd0, r0}, 32'hFF);
    check("rsp_miso_b1", {24'd0, r1}, 32'hA5);
    check("rsp_miso_b2", {24'd0, r2}, 32'hFF);
    check("rsp_tx_ready", tr_cnt, 32'd1);

    // Aborted byte after 5 bits, then a clean frame
    clr();
    spi_csb = 1'b0;
    #30;
    spi_byte(8'hB7, 5, -1, r0);
    spi_csb = 1'b1;
    #100;
    check("abt_rx_count", rxq_d.size(), 32'd0);
    check("abt_frame_end", fe_cnt, 32'd1);
    clr();
    spi_csb = 1'b0;
    #30;
    spi_byte(8'h23, 8, -1, r0);
    spi_csb = 1'b1;
    #100;
    check("abt_next_count", rxq_d.size(), 32'd1);
    check("abt_next_d", {24'd0, rx_d_at(0)}, 32'h23);
    check("abt_next_first", {31'd0, rx_f_at(0)}, 32'd1);
    check("abt_next_fe", fe_cnt, 32'd1);

    // Reset during bit 3 with csb held low
    clr();
    spi_csb = 1'b0;
    #30;
    spi_byte(8'h24, 3, -1, r0);
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    #2 resetn = 1'b1;
    #8;
    spi_byte(8'h55, 8, -1, r0);
    spi_byte(8'h66, 8, -1, r0);
    spi_csb = 1'b1;
    #100;
    check("rmf_rx_count", rxq_d.size(), 32'd0);
    check("rmf_frame_end", fe_cnt, 32'd0);
    check("rmf_tx_ready", tr_cnt, 32'd0);
    clr();
    spi_csb = 1'b0;
    #30;
    spi_byte(8'h24, 8, -1, r0);
    spi_csb = 1'b1;
    #100;
    check("rmf_next_count", rxq_d.size(), 32'd1);
    check("rmf_next_d", {24'd0, rx_d_at(0)}, 32'h24);
    check("rmf_next_first", {31'd0, rx_f_at(0)}, 32'd1);

    // csb rises one clock after the 8th spi_clk rise
    clr();
    b = 8'h3C;
    spi_csb = 1'b0;
    #30;
    spi_byte(b, 7, -1, r0);
    spi_clk  = 1'b0;
    spi_mosi = b[0];
    #30 spi_clk = 1'b1;
    #10 spi_csb = 1'b1;
    #100;
    check("bnd_rx_count", rxq_d.size(), 32'd1);
    check("bnd_d", {24'd0, rx_d_at(0)}, 32'h3C);
    check("bnd_fe", fe_cnt, 32'd1);
    check("bnd_order", {31'd0, (fe_cnt > 0) && (rxq_d.size() > 0) && (rx_cyc <= fe_cyc)}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mlaccel_spi_slave.md
Name: mlaccel_spi_slave

Overview:
SPI target front-end inside mlaccel_top, driven by the external host that issues command bytes (0x21..0x24, etc.).
- Oversamples spi_csb/spi_clk/spi_mosi in the system clock domain.
- Deserialises MSB-first bytes into a valid-strobed stream for the command decoder.
- Serialises response bytes from the decoder onto spi_miso.
- SPI mode 3: clock idles high; host drives data after the falling edge and samples after the rising edge.

Parameters:
SYNC_STAGES  2  synchroniser flops on spi_csb/spi_clk/spi_mosi; legal values 2..3
TX_FILL  8'hFF  byte shifted out when no tx byte is available at a byte boundary

Ports:
clock  input  1  system clock
resetn  input  1  synchronous active-low reset
spi_csb  input  1  chip select, active low, asynchronous to clock
spi_clk  input  1  SPI clock, asynchronous, idles high
spi_mosi  input  1  host-to-target data
spi_miso  output  1  target-to-host data
rx_valid  output  1  one-cycle strobe: rx_data holds a complete byte
rx_data  output  8  received byte, held until next rx_valid
rx_first  output  1  qualifies rx_valid: byte is first of frame (command byte)
frame_active  output  1  synchronised, inverted spi_csb
frame_end  output  1  one-cycle strobe on synchronised csb rising edge
tx_valid  input  1  decoder offers tx_data
tx_data  input  8  next response byte
tx_ready  output  1  one-cycle strobe: tx_data consumed this cycle

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-low (resetn).
- Reset values:
  - rx_valid, rx_first, frame_end, tx_ready, frame_active: 0.
  - rx_data: 0.
  - spi_miso: 0, or Z (see Optional Feature).
  - Synchroniser flops: 1 (idle levels).
  - Bit counter: 0.
  - Resync flag: set.
- Edge detection:
  - Registered compare of the last two sync stages.
  - Host must hold each spi_clk phase ≥ 2 clock periods.
  - csb must be low ≥ 2 clock periods before the first spi_clk fall.
- States: IDLE, ACTIVE, RESYNC.
  - IDLE -> ACTIVE on synchronised csb fall.
  - ACTIVE -> IDLE on csb rise.
  - Reset enters RESYNC if csb is sampled low, otherwise IDLE.
  - RESYNC ignores all edges and waits for csb high, then goes to IDLE. No strobes are generated in RESYNC.
- On entry to ACTIVE:
  - Bit counter = 0, rx_first pending = 1.
  - Tx byte load per the load rule below.
- Rx path (ACTIVE only):
  - On each detected spi_clk rise, shift synchronised mosi into an 8-bit shift register, MSB first, and increment the bit counter (3 bits, wraps 7->0).
  - On the 8th rise: rx_data <= the assembled byte; rx_valid = 1 in the following cycle. rx_valid is asserted ≤ SYNC_STAGES+2 clocks after the spi_clk rise.
  - rx_first = pending flag. The flag clears after the first delivered byte.
- Tx path: tx byte load rule, applied at frame start and in the cycle after each 8th rise.
  - If tx_valid: latch tx_data and pulse tx_ready.
  - Otherwise: latch TX_FILL, no tx_ready.
  - On each detected spi_clk fall in ACTIVE: spi_miso <= tx shift MSB, then shift left. The first fall of each byte therefore presents bit 7.
  - spi_miso holds between falls.
- Frame end:
  - frame_end pulses 1 cycle after synchronised csb rise.
  - A partial byte (bit counter ≠ 0) is discarded silently; the bit counter resets.
  - A loaded but unsent tx byte is dropped; its tx_ready was already given.
- Simultaneous events:
  - 8th rise and csb rise detected in the same cycle: the byte is delivered (rx_valid) before or with frame_end. Never lost.
  - tx_valid arriving in the load cycle counts; arriving later waits for the next boundary.
- The bench's no-data "wait" byte is simply a byte whose rx_valid is delivered. Discarding it is the decoder's job.

Optional Feature:
SPI_TRISTATE_EN
- Defined: spi_miso = 1'bz whenever not in ACTIVE (csb high, reset, RESYNC); driven only while ACTIVE.
- Undefined: spi_miso is always driven, 0 outside ACTIVE.
- Internal logic is identical in both builds.

Test Plan:
- Reset check: resetn low 3 cycles with csb high -> all strobes 0, frame_active 0. spi_miso 0, or Z with SPI_TRISTATE_EN.
- Single frame: host sends 0x21, 0x05 (half period 30 ns) -> rx_valid twice.
  - First strobe: rx_data=0x21, rx_first=1.
  - Second strobe: rx_data=0x05, rx_first=0.
  - frame_end once after csb rise.
- Response: decoder holds tx_valid=1, tx_data=0xA5 after command 0x22 -> host reads 0xA5 on the byte after the command; tx_ready pulses once per consumed byte.
  - Underrun: with tx_valid=0, the next byte reads 0xFF (TX_FILL).
- Aborted byte: csb rises after 5 bits -> no rx_valid, frame_end=1. The next frame's first byte 0x23 arrives with rx_first=1 and correct value.
- Reset mid-frame: assert resetn low during bit 3 while csb stays low -> no strobes for the rest of that frame. After csb high/low, a new frame with 0x24 is received correctly.
- Boundary: csb rises 1 clock after the 8th spi_clk rise -> rx_valid for that byte still occurs, no later than frame_end.
